// File: rtl/addsub_arbiter_pkg.sv
// Shared types and constants for the add/sub arbiter and its datapath core.
package addsub_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_N_REQ = 2;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple-carry add/subtract: A + (B ^ {~mode}) + ~mode.
import addsub_arbiter_pkg::*;

module addsub_core #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic             inv_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   carry_s;

  assign inv_s      = (mode == MODE_SUB);
  assign b_eff_s    = b ^ {WIDTH{inv_s}};
  assign carry_s[0] = inv_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]         = a[i] ^ b_eff_s[i] ^ carry_s[i];
    assign carry_s[i + 1] = (a[i] & b_eff_s[i]) | (carry_s[i] & (a[i] ^ b_eff_s[i]));
  end

  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub core between N_REQ requesters,
// returning a registered, ID-tagged result under a valid/ready handshake.
import addsub_arbiter_pkg::*;

module addsub_arbiter #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int ID_W  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_mode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout
);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_last_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [ID_W-1:0]  id_q;
  logic             rsp_valid_q, rsp_cout_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;

  logic             found_s, win_mode_s, load_op_s, load_rsp_s, clr_rsp_s;
  logic [ID_W-1:0]  win_id_s;
  logic [N_REQ-1:0] grant_oh_s;
  logic [WIDTH-1:0] win_a_s, win_b_s, core_sum_s;
  logic             core_cout_s;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (a_q),
    .b    (b_q),
    .mode (mode_q),
    .sum  (core_sum_s),
    .cout (core_cout_s)
  );

  // Round-robin pick: scan candidates starting just after the last winner.
  always_comb begin
    found_s    = 1'b0;
    win_id_s   = '0;
    grant_oh_s = '0;
    win_a_s    = '0;
    win_b_s    = '0;
    win_mode_s = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!found_s && req_valid[j] && (j == (int'(rr_last_q) + 1 + k) % N_REQ)) begin
          found_s       = 1'b1;
          win_id_s      = ID_W'(j);
          grant_oh_s[j] = 1'b1;
          win_a_s       = req_a[j*WIDTH +: WIDTH];
          win_b_s       = req_b[j*WIDTH +: WIDTH];
          win_mode_s    = req_mode[j];
        end
      end
    end
  end

  // Next-state and handshake decode; req_ready is also gated off while in reset.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    load_op_s  = 1'b0;
    load_rsp_s = 1'b0;
    clr_rsp_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_s && rst_n) begin
          req_ready = grant_oh_s;
          load_op_s = 1'b1;
          state_d   = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        load_rsp_s = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          clr_rsp_s = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_last_q   <= ID_W'(N_REQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_op_s) begin
        a_q       <= win_a_s;
        b_q       <= win_b_s;
        mode_q    <= win_mode_s;
        id_q      <= win_id_s;
        rr_last_q <= win_id_s;
      end
      if (load_rsp_s) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_sum_q   <= core_sum_s;
        rsp_cout_q  <= core_cout_s;
      end else if (clr_rsp_s) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (WIDTH=4, N_REQ=2).
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a, req_b;
  logic [1:0] req_mode;
  logic       rsp_valid, rsp_ready;
  logic [0:0] rsp_id;
  logic [3:0] rsp_sum;
  logic       rsp_cout;

  int pass_cnt = 0;
  int total    = 0;

  addsub_arbiter #(.WIDTH(4), .N_REQ(2), .ID_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic m);
    req_a[id*4 +: 4] = a;
    req_b[id*4 +: 4] = b;
    req_mode[id]     = m;
  endtask

  // Lone request from one requester with rsp_ready held high.
  task automatic single(input string tag, input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic m, input logic [3:0] exp_sum, input logic exp_cout);
    tick();
    set_req(id, a, b, m);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    rsp_ready     = 1'b1;
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(2'b01 << id));
    tick();
    req_valid = 2'b00;
    #1;
    chk({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_sum"}, 32'(rsp_sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(rsp_cout), 32'(exp_cout));
    tick();
    chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_a     = 8'h00;
    req_b     = 8'h00;
    req_mode  = 2'b00;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_cout", 32'(rsp_cout), 32'd0);
    req_valid = 2'b11;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;

    single("add_3_4", 0, 4'd3, 4'd4, 1'b1, 4'd7, 1'b0);
    single("sub_2_5", 1, 4'd2, 4'd5, 1'b0, 4'hD, 1'b0);
    single("sub_9_9", 1, 4'd9, 4'd9, 1'b0, 4'h0, 1'b1);
    single("add_F_1", 0, 4'hF, 4'h1, 1'b1, 4'h0, 1'b1);
    single("sub_0_1", 1, 4'h0, 4'h1, 1'b0, 4'hF, 1'b0);

    // Contention: both held; grants alternate 0,1,0,1 every 3 cycles.
    tick();
    set_req(0, 4'd1, 4'd2, 1'b1);
    set_req(1, 4'd5, 4'd3, 1'b0);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int t = 0; t < 12; t++) begin
      automatic int ph = t % 3;
      automatic int id = (t / 3) % 2;
      if (ph == 0) begin
        chk("rr_grant", 32'(req_ready), 32'(2'b01 << id));
      end else if (ph == 1) begin
        chk("rr_exec_ready", 32'(req_ready), 32'd0);
      end else begin
        chk("rr_valid", 32'(rsp_valid), 32'd1);
        chk("rr_id", 32'(rsp_id), 32'(id));
        chk("rr_sum", 32'(rsp_sum), (id == 0) ? 32'd3 : 32'd2);
        chk("rr_cout", 32'(rsp_cout), (id == 0) ? 32'd0 : 32'd1);
      end
      tick();
    end

    // Backpressure: req0 wins, response held 5 cycles, req1 waits.
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant0", 32'(req_ready), 32'd1);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_sum", 32'(rsp_sum), 32'd3);
      chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'd0);
    tick();
    chk("bp_grant1", 32'(req_ready), 32'd2);
    chk("bp_valid_low", 32'(rsp_valid), 32'd0);
    tick();

    // Reset during EXEC clears the previous result registers.
    req_valid = 2'b00;
    rst_n     = 1'b0;
    #1;
    chk("rexec_valid", 32'(rsp_valid), 32'd0);
    chk("rexec_sum", 32'(rsp_sum), 32'd0);
    chk("rexec_id", 32'(rsp_id), 32'd0);
    chk("rexec_ready", 32'(req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rexec_idle_valid", 32'(rsp_valid), 32'd0);
    end
    req_valid = 2'b11;
    #1;
    chk("post_rst_grant0", 32'(req_ready), 32'd1);
    tick();
    tick();
    chk("rresp_valid_hi", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rresp_valid", 32'(rsp_valid), 32'd0);
    chk("rresp_ready", 32'(req_ready), 32'd0);
    req_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rresp_no_rsp", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
